// File: rtl/touch_key_ctrl.sv
// touch_key_ctrl
//   Debounces three touch-key levels and turns each accepted touch into a
//   single action on the gate / counting state.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   op_cl        open/close key level
//   pl_pa        play/pause key level
//   clear        clear key level
//   opened       registered gate state (1 = open)
//   playing      registered counting state (1 = play)
//   clear_pulse  one-cycle count-clear request
//   busy         high whenever the FSM is not in IDLE
module touch_key_ctrl #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter logic [15:0] REL_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic op_cl,
  input  logic pl_pa,
  input  logic clear,
  output logic opened,
  output logic playing,
  output logic clear_pulse,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACTIVE, RELEASE} state_t;

  // Thresholds below 1 behave as 1.
  localparam logic [15:0] DEB_EFF = (DEB_CYCLES < 16'd2) ? 16'd1 : DEB_CYCLES;
  localparam logic [15:0] REL_EFF = (REL_CYCLES < 16'd2) ? 16'd1 : REL_CYCLES;

  state_t      state;
  logic [2:0]  code_q;
  logic [2:0]  key_lat;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        code_valid;
  logic        opened_act;
  logic        playing_act;

  // Multi-key codes fall out as not-valid, i.e. NONE.
  assign code_valid = (code_q == 3'b001) || (code_q == 3'b010) || (code_q == 3'b100);
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + 16'd1;
  assign busy       = (state != IDLE);

  // Action results; only used on an edge where code_q equals the accepted key.
  always_comb begin
    opened_act  = opened;
    playing_act = playing;
    if (code_q[0]) begin
      opened_act = ~opened;
      if (opened) playing_act = 1'b0;
    end else if (code_q[1]) begin
      if (opened) playing_act = ~playing;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      key_lat     <= '0;
      code_q      <= '0;
      opened      <= 1'b0;
      playing     <= 1'b0;
      clear_pulse <= 1'b0;
    end else begin
      code_q      <= {clear, pl_pa, op_cl};
      clear_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (code_valid) begin
            key_lat <= code_q;
            cnt     <= 16'd1;
            // With a one-sample debounce the first valid sample is accepted.
            if (DEB_EFF == 16'd1) begin
              opened      <= opened_act;
              playing     <= playing_act;
              clear_pulse <= code_q[2];
              state       <= ACTIVE;
            end else begin
              state <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (code_q == key_lat) begin
            cnt <= cnt_inc;
            if (cnt_inc >= DEB_EFF) begin
              opened      <= opened_act;
              playing     <= playing_act;
              clear_pulse <= code_q[2];
              state       <= ACTIVE;
            end
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        ACTIVE: begin
          if (!code_valid) begin
            cnt   <= 16'd1;
            state <= (REL_EFF == 16'd1) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (!code_valid) begin
            cnt <= cnt_inc;
            if (cnt_inc >= REL_EFF) state <= IDLE;
          end else begin
            state <= ACTIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_touch_key_ctrl.sv
module tb_touch_key_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic op_cl = 1'b0, pl_pa = 1'b0, clear = 1'b0;
  logic a_opened, a_playing, a_pulse, a_busy;
  logic b_opened, b_playing, b_pulse, b_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  touch_key_ctrl #(.DEB_CYCLES(16'd4), .REL_CYCLES(16'd3)) dut_a (
    .clk(clk), .reset(reset), .op_cl(op_cl), .pl_pa(pl_pa), .clear(clear),
    .opened(a_opened), .playing(a_playing), .clear_pulse(a_pulse), .busy(a_busy)
  );

  touch_key_ctrl #(.DEB_CYCLES(16'd0), .REL_CYCLES(16'd1)) dut_b (
    .clk(clk), .reset(reset), .op_cl(op_cl), .pl_pa(pl_pa), .clear(clear),
    .opened(b_opened), .playing(b_playing), .clear_pulse(b_pulse), .busy(b_busy)
  );

  // Reference model: "armed" means ready to accept a touch; run counts
  // consecutive samples of one valid key, quiet counts consecutive NONE samples.
  typedef struct {
    logic [2:0] code;
    bit         armed;
    logic [2:0] key;
    int         run;
    int         quiet;
    bit         opened;
    bit         playing;
    bit         pulse;
  } mdl_t;

  function automatic mdl_t step(input mdl_t m, input bit rst, input logic [2:0] raw,
                                input int deb, input int rel);
    mdl_t n = m;
    logic [2:0] c;
    bit valid;
    if (rst) begin
      n.code = 3'b000; n.armed = 1'b1; n.key = 3'b000; n.run = 0; n.quiet = 0;
      n.opened = 1'b0; n.playing = 1'b0; n.pulse = 1'b0;
      return n;
    end
    c = m.code;
    n.code = raw;
    n.pulse = 1'b0;
    valid = (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    if (m.armed) begin
      if (valid && (m.run == 0 || c == m.key)) begin
        if (m.run == 0) n.key = c;
        n.run = m.run + 1;
        if (n.run >= deb) begin
          if (c == 3'b001) begin
            n.opened = !m.opened;
            if (m.opened) n.playing = 1'b0;
          end else if (c == 3'b010) begin
            if (m.opened) n.playing = !m.playing;
          end else begin
            n.pulse = 1'b1;
          end
          n.armed = 1'b0;
          n.run = 0;
          n.quiet = 0;
        end
      end else begin
        n.run = 0;
      end
    end else begin
      if (!valid) begin
        n.quiet = m.quiet + 1;
        if (n.quiet >= rel) begin
          n.armed = 1'b1;
          n.run = 0;
        end
      end else begin
        n.quiet = 0;
      end
    end
    return n;
  endfunction

  mdl_t ma, mb;
  logic [3:0] qa[$];
  logic [3:0] qb[$];

  // Stimulus side: advance the models and push expected outputs per edge.
  always @(posedge clk) begin
    ma = step(ma, reset, {clear, pl_pa, op_cl}, 4, 3);
    mb = step(mb, reset, {clear, pl_pa, op_cl}, 1, 1);
    qa.push_back({ma.opened, ma.playing, ma.pulse, !ma.armed || (ma.run > 0)});
    qb.push_back({mb.opened, mb.playing, mb.pulse, !mb.armed || (mb.run > 0)});
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: pop one expectation per DUT per edge and compare.
  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (qa.size() == 0 || qb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty at %0t: got empty queue expected entry", $time);
    end else begin
      e = qa.pop_front();
      check("a_opened",  a_opened,  e[3]);
      check("a_playing", a_playing, e[2]);
      check("a_clear_pulse", a_pulse, e[1]);
      check("a_busy",    a_busy,    e[0]);
      e = qb.pop_front();
      check("b_opened",  b_opened,  e[3]);
      check("b_playing", b_playing, e[2]);
      check("b_clear_pulse", b_pulse, e[1]);
      check("b_busy",    b_busy,    e[0]);
    end
  end

  task automatic drive(input logic [2:0] c, input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = r;
      {clear, pl_pa, op_cl} = c;
    end
  endtask

  initial begin
    drive(3'b000, 2, 1'b1);
    drive(3'b001, 10, 1'b0);   // open
    drive(3'b000, 8, 1'b0);
    drive(3'b001, 3, 1'b0);    // too short for the slow instance
    drive(3'b000, 6, 1'b0);
    drive(3'b010, 8, 1'b0);    // play
    drive(3'b000, 8, 1'b0);
    drive(3'b001, 8, 1'b0);    // close, forces pause
    drive(3'b000, 8, 1'b0);
    drive(3'b010, 8, 1'b0);    // ignored while closed
    drive(3'b000, 8, 1'b0);
    drive(3'b100, 20, 1'b0);   // single clear pulse
    drive(3'b000, 8, 1'b0);
    drive(3'b011, 10, 1'b0);   // two keys = NONE
    drive(3'b010, 8, 1'b0);    // one released, debounce remaining key
    drive(3'b000, 8, 1'b0);
    drive(3'b001, 8, 1'b0);
    drive(3'b000, 2, 1'b0);    // brief drop during release
    drive(3'b001, 4, 1'b0);
    drive(3'b000, 8, 1'b0);
    drive(3'b001, 2, 1'b0);    // reset mid-debounce, key held through
    drive(3'b001, 1, 1'b1);
    drive(3'b001, 8, 1'b0);
    drive(3'b000, 8, 1'b0);
    for (int s = 0; s < 300; s++) begin
      logic [2:0] c;
      int unsigned len;
      c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) c = 3'b000;
      len = $urandom_range(1, 12);
      drive(c, int'(len), ($urandom_range(0, 39) == 0));
    end
    drive(3'b000, 10, 1'b0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/touch_key_ctrl.md
TOUCH_KEY_CTRL -- requirements
Module: touch_key_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 16'd50000: consecutive clk samples a key code must stay stable before it is accepted.
REQ-002 Parameter REL_CYCLES, default 16'd50000: consecutive all-zero samples required before the block re-arms after a press.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op_cl  input  1  level, high while the open/close key region is touched (from the touch region decoder).
REQ-006 pl_pa  input  1  level, high while the play/pause key region is touched.
REQ-007 clear  input  1  level, high while the clear key region is touched.
REQ-008 opened  output  1  registered gate state: 1 = open, 0 = closed.
REQ-009 playing  output  1  registered counting state: 1 = play, 0 = pause.
REQ-010 clear_pulse  output  1  one-cycle pulse requesting a count clear.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 Inputs SHALL be registered once into a 3-bit code {clear, pl_pa, op_cl}; only that registered code feeds the FSM.
REQ-013 A code with zero bits set is NONE; exactly one bit set is a valid key; two or more bits set SHALL be treated as NONE.
REQ-014 FSM states: IDLE, DEBOUNCE, ACTIVE, RELEASE; 16-bit counter cnt shared by DEBOUNCE and RELEASE.
REQ-015 IDLE: on a valid key, latch it as key_lat, load cnt=1, go to DEBOUNCE; on NONE, stay.
REQ-016 DEBOUNCE: code equal to key_lat -> cnt+1; code different (including NONE or another key) -> cnt=0, go to IDLE with no action.
REQ-017 DEBOUNCE: on the edge where cnt would reach DEB_CYCLES, execute the key action and go to ACTIVE.
REQ-018 Action latency: outputs change on the (DEB_CYCLES+1)th rising edge after the first edge that samples the key high on the raw input.
REQ-019 op_cl action: opened toggles; if opened goes 1->0, playing SHALL be forced to 0 on the same edge.
REQ-020 pl_pa action: playing toggles only when opened=1; when opened=0 the press is consumed and playing stays 0.
REQ-021 clear action: clear_pulse=1 for exactly one cycle; opened and playing unchanged.
REQ-022 Exactly one action SHALL occur per touch, regardless of hold duration.
REQ-023 ACTIVE: on NONE, cnt=1 and go to RELEASE; otherwise stay, with no further action.
REQ-024 RELEASE: NONE -> cnt+1, and on reaching REL_CYCLES go to IDLE; any non-NONE code -> go back to ACTIVE with no action.
REQ-025 Counters SHALL saturate and never wrap; DEB_CYCLES or REL_CYCLES of 0 or 1 SHALL act as 1.
REQ-026 clear_pulse SHALL be 0 in every cycle except the action cycle of a clear press.

Reset
REQ-027 While reset=1 at a rising edge: state=IDLE, cnt=0, key_lat=0, input register=0, opened=0, playing=0, clear_pulse=0, busy=0.
REQ-028 Reset asserted mid-debounce or mid-release SHALL abort with no action, and reset has priority over any simultaneous action.
REQ-029 After reset deasserts, a key held continuously through reset SHALL be debounced from scratch and produce one action.

Verification (DEB_CYCLES=4, REL_CYCLES=3)
REQ-030 Reset, then op_cl high for 10 cycles, then low -> opened rises on the 5th edge after op_cl is first sampled; busy falls 3 cycles after the registered code returns to NONE.
REQ-031 op_cl high for 3 cycles, then low -> no output change; FSM returns to IDLE.
REQ-032 With opened=1: pl_pa press -> playing=1; op_cl press -> opened=0 and playing=0 on the same edge; pl_pa press -> playing remains 0.
REQ-033 clear held for 20 cycles -> exactly one clear_pulse, 1 cycle wide, on the 5th edge; no further pulses.
REQ-034 op_cl and pl_pa high simultaneously for 10 cycles -> no action; one key released mid-hold -> debounce restarts from the remaining key.
REQ-035 Press accepted, touch drops to NONE for 2 cycles then returns -> FSM goes back to ACTIVE with no second action; reset asserted in DEBOUNCE -> all outputs 0 on the next edge.
